sync_filter: RTL and testbench

- Parametrised multi-channel input conditioner for the external pixel, weight and enable strobes feeding the BNN datapath.
- Each channel passes through a configurable-depth synchroniser, then a per-channel glitch filter (consecutive-cycle debounce).
- Produces a clean level per channel, single-cycle rise and fall pulses, and a saturating count of rejected glitches.
- Sits between the chip input pads and the input shift/control logic; it replaces the fixed 3-channel, 3-stage synchroniser.

---
 rtl/sync_filter.sv | 93 +++++++++
 tb/tb_sync_filter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_filter.sv
// sync_filter: multi-channel synchroniser plus consecutive-cycle glitch filter.
// Emits clean levels, rise/fall pulses and a saturating rejected-glitch count.
module sync_filter #(
    parameter int                NUM_CH        = 3,
    parameter int                SYNC_STAGES   = 3,
    parameter int                FILTER_CYCLES = 4,
    parameter logic [NUM_CH-1:0] RESET_VAL     = '0,
    parameter int                GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   async_in,
    input  logic                glitch_clr,
    output logic [NUM_CH-1:0]   sync_out,
    output logic [NUM_CH-1:0]   rise,
    output logic [NUM_CH-1:0]   fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam int SW = GLITCH_W + $clog2(NUM_CH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [SW-1:0] SAT = SW'({GLITCH_W{1'b1}});

    // Pad capture flop plus SYNC_STAGES resolution flops; raw is the tail.
    logic [NUM_CH-1:0] chain [SYNC_STAGES+1];
    logic [NUM_CH-1:0] raw;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic [NUM_CH-1:0] out_d;
    logic [NUM_CH-1:0] rise_d;
    logic [NUM_CH-1:0] fall_d;
    logic [NUM_CH-1:0] reject;
    logic [SW-1:0]     sum;
    logic [GLITCH_W-1:0] glitch_d;

    assign raw = chain[SYNC_STAGES];

    always_comb begin
        out_d  = sync_out;
        rise_d = '0;
        fall_d = '0;
        reject = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (raw[i] == sync_out[i]) begin
                reject[i] = (cnt_q[i] != '0);
            end else if (cnt_q[i] == CNT_LAST) begin
                out_d[i]  = raw[i];
                rise_d[i] = raw[i];
                fall_d[i] = ~raw[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        sum = SW'(glitch_cnt);
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + SW'(reject[i]);
        end
        glitch_d = (sum > SAT) ? '1 : sum[GLITCH_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s <= SYNC_STAGES; s++) begin
                chain[s] <= RESET_VAL;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            sync_out   <= RESET_VAL;
            rise       <= '0;
            fall       <= '0;
            glitch_cnt <= '0;
        end else begin
            chain[0] <= async_in;
            for (int s = 1; s <= SYNC_STAGES; s++) begin
                chain[s] <= chain[s-1];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sync_out   <= out_d;
            rise       <= rise_d;
            fall       <= fall_d;
            glitch_cnt <= glitch_clr ? '0 : glitch_d;
        end
    end

endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: reference-model and directed checks for sync_filter.
// Three instances: base config, RESET_VAL=101, FILTER_CYCLES=1.
module tb_sync_filter;

    localparam int SS = 3;
    localparam int FC = 4;
    localparam int GMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, clr0, rst1, clr1, rst2, clr2;
    logic [2:0] a0, a1, a2;
    logic [2:0] s0, r0, f0, s1, r1, f1, s2, r2, f2;
    logic [3:0] g0, g1, g2;

    int checks = 0;
    int failures = 0;

    sync_filter #(
        .NUM_CH(3), .SYNC_STAGES(SS), .FILTER_CYCLES(FC),
        .RESET_VAL(3'b000), .GLITCH_W(4)
    ) u0 (
        .clk(clk), .reset(rst0), .async_in(a0), .glitch_clr(clr0),
        .sync_out(s0), .rise(r0), .fall(f0), .glitch_cnt(g0)
    );

    sync_filter #(
        .NUM_CH(3), .SYNC_STAGES(SS), .FILTER_CYCLES(FC),
        .RESET_VAL(3'b101), .GLITCH_W(4)
    ) u1 (
        .clk(clk), .reset(rst1), .async_in(a1), .glitch_clr(clr1),
        .sync_out(s1), .rise(r1), .fall(f1), .glitch_cnt(g1)
    );

    sync_filter #(
        .NUM_CH(3), .SYNC_STAGES(SS), .FILTER_CYCLES(1),
        .RESET_VAL(3'b000), .GLITCH_W(4)
    ) u2 (
        .clk(clk), .reset(rst2), .async_in(a2), .glitch_clr(clr2),
        .sync_out(s2), .rise(r2), .fall(f2), .glitch_cnt(g2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model for u0: raw is async_in delayed by the sync depth, and a
    // level is accepted once raw has differed for FC straight samples.
    bit [2:0] m_hist[$];
    bit [2:0] m_out, m_rise, m_fall;
    int       m_run[3];
    int       m_gc;
    bit       m_valid = 1'b0;

    task automatic model_edge();
        bit [2:0] raw;
        int rej;
        if (rst0) begin
            m_hist = {};
            repeat (SS + 1) m_hist.push_back(3'b000);
            m_out = 0; m_rise = 0; m_fall = 0; m_gc = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            raw = m_hist.pop_front();
            m_hist.push_back(a0);
            rej = 0; m_rise = 0; m_fall = 0;
            for (int i = 0; i < 3; i++) begin
                if (raw[i] == m_out[i]) begin
                    if (m_run[i] > 0) rej++;
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == FC) begin
                        m_out[i]  = raw[i];
                        m_rise[i] = raw[i];
                        m_fall[i] = ~raw[i];
                        m_run[i]  = 0;
                    end
                end
            end
            if (clr0) m_gc = 0;
            else m_gc = (m_gc + rej > GMAX) ? GMAX : m_gc + rej;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) begin
            check("mdl_out", s0, m_out);
            check("mdl_rise", r0, m_rise);
            check("mdl_fall", f0, m_fall);
            check("mdl_gcnt", g0, m_gc);
        end
    endtask

    int rise_at, fall_at;

    initial begin
        rst0 = 1; clr0 = 0; a0 = 0;
        rst1 = 1; clr1 = 0; a1 = 0;
        rst2 = 1; clr2 = 0; a2 = 0;
        repeat (2) tick();
        rst0 = 0;
        check("rst_out", s0, 3'b000);
        check("rst_rise", r0, 3'b000);
        check("rst_fall", f0, 3'b000);
        check("rst_gcnt", g0, 0);
        check("rst1_out", s1, 3'b101);

        // clean step on channel 0
        a0 = 3'b001;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (e == 6) check("step_pre", s0, 3'b000);
            if (e == 7) begin
                check("step_out", s0, 3'b001);
                check("step_rise", r0, 3'b001);
            end
            if (e == 8) check("step_rise_end", r0, 3'b000);
        end
        a0 = 3'b000;
        repeat (10) tick();

        // 3-cycle pulse rejected, then 4-cycle pulse accepted
        for (int e = 0; e < 12; e++) begin
            a0 = (e < 3) ? 3'b010 : 3'b000;
            tick();
            check("p3_hold", s0, 3'b000);
        end
        check("p3_gcnt", g0, 1);
        rise_at = -1; fall_at = -1;
        for (int e = 0; e < 16; e++) begin
            a0 = (e < 4) ? 3'b010 : 3'b000;
            tick();
            if (r0[1] && rise_at < 0) rise_at = e;
            if (f0[1] && fall_at < 0) fall_at = e;
        end
        check("p4_rise_at", rise_at, 7);
        check("p4_fall_at", fall_at, 11);
        check("p4_gcnt", g0, 1);

        // simultaneous 2-cycle glitches on channels 0 and 2
        for (int e = 0; e < 10; e++) begin
            a0 = (e < 2) ? 3'b101 : 3'b000;
            tick();
            if (e == 5) check("sim_before", g0, 1);
            if (e == 6) check("sim_after", g0, 3);
        end
        check("sim_out", s0, 3'b000);

        // saturation then clear colliding with a reject
        clr0 = 1; tick(); clr0 = 0;
        check("clr_gcnt", g0, 0);
        for (int k = 1; k <= 17; k++) begin
            a0 = 3'b001; tick(); a0 = 3'b000;
            repeat (6) tick();
            check($sformatf("sat_%0d", k), g0, (k > GMAX) ? GMAX : k);
        end
        a0 = 3'b001; tick(); a0 = 3'b000;
        repeat (4) tick();
        check("clr_pre", g0, GMAX);
        clr0 = 1; tick(); clr0 = 0;
        check("clr_collide", g0, 0);

        // randomized runs against the model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(2) == 0) a0[i] = ~a0[i];
            clr0 = ($urandom_range(39) == 0);
            tick();
        end
        clr0 = 0;

        // mid-operation reset with RESET_VAL=101
        a1 = 3'b010;
        rst1 = 0;
        for (int e = 0; e < 6; e++) begin
            tick();
            check("mr_hold", s1, 3'b101);
        end
        rst1 = 1;
        tick();
        check("mr_out", s1, 3'b101);
        check("mr_rise", r1, 3'b000);
        check("mr_fall", f1, 3'b000);
        check("mr_gcnt", g1, 0);
        rst1 = 0;
        for (int e = 0; e < 9; e++) begin
            tick();
            if (e < 7) begin
                check("mr2_hold", s1, 3'b101);
                check("mr2_rf", {r1, f1}, 6'b0);
            end
            if (e == 7) begin
                check("mr2_out", s1, 3'b010);
                check("mr2_rise", r1, 3'b010);
                check("mr2_fall", f1, 3'b101);
            end
            if (e == 8) check("mr2_rf_end", {r1, f1}, 6'b0);
        end
        check("mr2_gcnt", g1, 0);

        // FILTER_CYCLES=1 passes a 1-cycle pulse
        rst2 = 0;
        tick();
        for (int e = 0; e < 8; e++) begin
            a2 = (e == 0) ? 3'b001 : 3'b000;
            tick();
            if (e == 4) begin
                check("mf_out", s2, 3'b001);
                check("mf_rise", r2, 3'b001);
                check("mf_fall", f2, 3'b000);
            end else if (e == 5) begin
                check("mf_out0", s2, 3'b000);
                check("mf_fall1", f2, 3'b001);
                check("mf_rise0", r2, 3'b000);
            end else begin
                check("mf_idle", {s2, r2, f2}, 9'b0);
            end
        end
        check("mf_gcnt", g2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
